// File: rtl/seq_signed_multiplier.sv
// Iterative WIDTH x WIDTH multiplier, one shift-add step per cycle, signed or unsigned per operation.
// Optional ZERO_SKIP_EN: a zero operand finishes after one cycle without asserting busy.
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] AB
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    ab_q;
  logic             sgn_q;
  logic             busy_q;
  logic             done_q;

  logic [PW-1:0]    a_ext_d;
  logic [PW-1:0]    term_d;
  logic [PW-1:0]    acc_d;

`ifdef ZERO_SKIP_EN
  logic             zero_q;
  logic             zero_d;
  assign zero_d = (A == '0) || (B == '0);
`endif

  // mcand_q is kept pre-shifted, so step i only looks at mplr_q[0].
  always_comb begin
    a_ext_d = signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    term_d  = mplr_q[0] ? mcand_q : '0;
    if (sgn_q && (cnt_q == LAST)) begin
      acc_d = acc_q - term_d;
    end else begin
      acc_d = acc_q + term_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      ab_q    <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ZERO_SKIP_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= a_ext_d;
            mplr_q  <= B;
            sgn_q   <= signed_mode;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef ZERO_SKIP_EN
            zero_q  <= zero_d;
            busy_q  <= !zero_d;
`else
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
`ifdef ZERO_SKIP_EN
          if (zero_q) begin
            ab_q    <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            zero_q  <= 1'b0;
            state_q <= FIN;
          end else
`endif
          begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              ab_q    <= acc_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= FIN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign AB   = ab_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench: WIDTH=8 directed cases plus WIDTH=4 exhaustive sweep against a behavioural model.
module tb_seq_signed_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] ab8;
  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  ab4;

  seq_signed_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .AB(ab8)
  );

  seq_signed_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .A(a4), .B(b4), .busy(busy4), .done(done4), .AB(ab4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [15:0] ab; int due; } exp8_t;
  typedef struct { logic [7:0]  ab; int due; } exp4_t;
  exp8_t q8[$];
  exp4_t q4[$];

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib, p;
    ia = s ? {{28{a[3]}}, a} : {28'b0, a};
    ib = s ? {{28{b[3]}}, b} : {28'b0, b};
    p  = ia * ib;
    return p[7:0];
  endfunction

  exp8_t e8;
  exp4_t e4;
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      chk("done8_busy", {31'b0, busy8}, 32'd0);
      if (q8.size() == 0) chk("done8_spurious", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("ab8", {16'b0, ab8}, {16'b0, e8.ab});
        chk("lat8", cyc, e8.due);
      end
    end
    if (done4 === 1'b1) begin
      chk("done4_busy", {31'b0, busy4}, 32'd0);
      if (q4.size() == 0) chk("done4_spurious", 32'd1, 32'd0);
      else begin
        e4 = q4.pop_front();
        chk("ab4", {24'b0, ab4}, {24'b0, e4.ab});
        chk("lat4", cyc, e4.due);
      end
    end
  end

  // Called on a negedge when the DUT will accept; returns one cycle later.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
    q8.push_back('{ab: exp, due: cyc + 9});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int due;
    due = cyc + 5;
`ifdef ZERO_SKIP_EN
    if (a == 4'd0 || b == 4'd0) due = cyc + 2;
`endif
    a4 = a; b4 = b; sm4 = s; start4 = 1'b1;
    q4.push_back('{ab: ref4(a, b, s), due: due});
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait8(input string tag);
    int n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done8 !== 1'b1) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait4(input string tag);
    int n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done4 !== 1'b1) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start8 = 1'($urandom); sm8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    start4 = 1'($urandom); sm4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy8", {31'b0, busy8}, 32'd0);
    chk("rst_done8", {31'b0, done8}, 32'd0);
    chk("rst_ab8",   {16'b0, ab8},   32'd0);
    chk("rst_busy4", {31'b0, busy4}, 32'd0);
    chk("rst_ab4",   {24'b0, ab4},   32'd0);
    start8 = 1'b0; start4 = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy8", {31'b0, busy8}, 32'd0);

    // Signed and corner values, issued back-to-back in each FIN cycle.
    go8(8'hFD, 8'h05, 1'b1, 16'hFFF1); wait8("to_a");
    go8(8'h7F, 8'hFF, 1'b1, 16'hFF81); wait8("to_b");
    go8(8'h80, 8'h80, 1'b1, 16'h4000); wait8("to_c");
    go8(8'hFF, 8'hFF, 1'b0, 16'hFE01); wait8("to_d");
    go8(8'hFF, 8'hFF, 1'b1, 16'h0001); wait8("to_e");
    repeat (3) @(negedge clk);
    chk("ab_hold", {16'b0, ab8}, 32'h0001);

    // Start and operand noise while running must not disturb the operation.
    go8(8'h0F, 8'h0F, 1'b0, 16'h00E1);
    chk("busy_run", {31'b0, busy8}, 32'd1);
    chk("ab_kept",  {16'b0, ab8},   32'h0001);
    for (int i = 0; i < 3; i++) begin
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm8;
      @(negedge clk);
      start8 = 1'b0;
    end
    wait8("to_f");
    go8(8'h02, 8'h03, 1'b0, 16'h0006); wait8("to_g");

    // Abort mid-operation.
    go8(8'h81, 8'h7E, 1'b1, 16'hC17E);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy8}, 32'd0);
    chk("abort_done", {31'b0, done8}, 32'd0);
    chk("abort_ab",   {16'b0, ab8},   32'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    go8(8'h81, 8'h7E, 1'b1, 16'hC17E); wait8("to_h");

    // WIDTH=4 exhaustive sweep, both modes.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          go4(4'(a), 4'(b), 1'(s));
          wait4("to_w4");
        end
      end
    end

    repeat (4) @(negedge clk);
    chk("sb8_empty", q8.size(), 32'd0);
    chk("sb4_empty", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_signed_multiplier.md
Name: seq_signed_multiplier

Overview:
- Parametrised, iterative successor to the team's 4-bit combinational Baugh-Wooley array multiplier.
- Multiplies two WIDTH-bit operands over WIDTH clock cycles using one shift-add step per cycle.
- Supports signed (two's complement) and unsigned modes, selected per operation.
- Used where an array multiplier is too large, behind a start/done handshake to the datapath controller.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- signed_mode  input  1  1 = two's complement operands, 0 = unsigned; captured with start
- A  input  WIDTH  multiplicand; captured with start
- B  input  WIDTH  multiplier; captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; AB valid
- AB  output  2*WIDTH  product; held until the next accepted start

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. Port names are clk and rst_n.
- Reset values: busy=0, done=0, AB=0, state=IDLE, counter=0, internal operand registers=0.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - FIN: done pulse.
- IDLE/FIN to RUN: taken on start=1.
  - Capture A, B and signed_mode.
  - Clear the accumulator and counter.
  - Set busy=1.
- FIN with start=0: go to IDLE.
- RUN, step i (counter i = 0..WIDTH-1):
  - If B[i]=1, the accumulator adds the multiplicand extended to 2*WIDTH bits and shifted left by i.
  - Extension is sign extension in signed mode and zero extension in unsigned mode.
  - In signed mode at i=WIDTH-1, the shifted multiplicand is subtracted instead of added (weight of the sign bit).
  - All arithmetic is modulo 2^(2*WIDTH).
- RUN to FIN: taken after step WIDTH-1.
  - AB is loaded with the final accumulator.
  - done=1 for exactly one cycle; busy=0 in that same cycle.
- Latency: start sampled at edge k; done and valid AB are visible after edge k+WIDTH.
- Back-to-back: start=1 in the FIN cycle is accepted. busy returns to 1 at the next edge and done drops.
- start while busy=1 is ignored. A, B and signed_mode changes during RUN have no effect.
- AB is unchanged from the end of one operation until the next FIN. It is not cleared by start.
- Results:
  - Unsigned mode gives the exact unsigned product.
  - Signed mode gives the exact signed product, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2), which has no overflow in 2*WIDTH bits.
- Reset asserted mid-operation: immediate return to reset values. No done is issued for the aborted operation.
- Counter width is clog2(WIDTH), with a minimum of 1 bit.

Optional Feature:
- Macro: ZERO_SKIP_EN
- Defined:
  - If the captured A or B equals 0, the IDLE/FIN to RUN transition goes directly to FIN instead.
  - AB=0 and done pulse are visible after edge k+1, with busy=1 for no cycle.
  - All other operands behave as in the base behaviour.
- Undefined:
  - Zero operands take the full WIDTH cycles and produce AB=0.
  - No comparator logic is present.

Test Plan:
- Reset checks: WIDTH=8, assert rst_n=0 with random inputs -> busy=0, done=0, AB=0x0000. Release, idle 5 cycles -> no done.
- Signed small values: WIDTH=8, signed_mode=1.
  - A=0xFD (-3), B=0x05 -> done after 8 cycles, AB=0xFFF1.
  - A=0x7F, B=0xFF (-1) -> AB=0xFF81.
- Corner values: WIDTH=8.
  - Signed A=0x80, B=0x80 -> AB=0x4000.
  - Unsigned A=0xFF, B=0xFF -> AB=0xFE01.
  - Signed A=0xFF, B=0xFF -> AB=0x0001.
- Handshake: start in FIN cycle with A=2, B=3 (unsigned) right after a 0x0F*0x0F operation.
  - First result: AB=0x00E1.
  - Second result: AB=0x0006 exactly 8 cycles later.
  - start pulses and operand changes during RUN are ignored.
- Reset mid-operation: start signed A=0x81, B=0x7E, pull rst_n low at cycle 4 -> busy=0, AB=0, and no done. A new start then completes normally with AB=0xC17E.
- Parametrisation and zero skip: WIDTH=4 exhaustive, all 256 pairs in both modes, compared against a reference model.
  - With ZERO_SKIP_EN: A=0 gives done one cycle after start.
  - Without ZERO_SKIP_EN: done after 4 cycles, AB=0.
